// File: rtl/riscv_timer_pkg.sv
// Shared definitions for the machine-timer front end: register map, ctrl bit
// positions and the control bundle that feeds the CSR block's timer inputs.
package riscv_timer_pkg;

    localparam logic [4:0] TIMER_ADDR_MTIME_LO = 5'h00;
    localparam logic [4:0] TIMER_ADDR_MTIME_HI = 5'h04;
    localparam logic [4:0] TIMER_ADDR_CMP_LO   = 5'h08;
    localparam logic [4:0] TIMER_ADDR_CMP_HI   = 5'h0C;
    localparam logic [4:0] TIMER_ADDR_CTRL     = 5'h10;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_CLEAR_BIT  = 1;
    localparam int CTRL_DIV_LSB    = 8;
    localparam int CTRL_DIV_MSB    = 15;

    typedef struct packed {
        logic        inc;
        logic        clear;
        logic        load;
        logic [63:0] value;
    } t_timer_controls;

    // Out-of-range or misaligned offsets get an error response.
    function automatic logic timer_addr_err(input logic [4:0] addr);
        return (addr > TIMER_ADDR_CTRL) || (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/riscv_timer_control_if.sv
// APB slave bus of the machine-timer block.
interface riscv_timer_control_if;
    logic        apb_psel;
    logic        apb_penable;
    logic        apb_pwrite;
    logic [4:0]  apb_paddr;
    logic [31:0] apb_pwdata;
    logic [31:0] apb_prdata;
    logic        apb_pready;
    logic        apb_pslverr;

    modport master (
        output apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata,
        input  apb_prdata, apb_pready, apb_pslverr
    );

    modport slave (
        input  apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata,
        output apb_prdata, apb_pready, apb_pslverr
    );
endinterface

// File: rtl/riscv_timer_prescaler.sv
// Tick prescaler: registered one-cycle tick every div+1 enabled clocks;
// restart zeroes the count and drops any tick in flight.
module riscv_timer_prescaler (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] i_div,
    input  logic       i_enable,
    input  logic       i_restart,
    output logic       o_tick
);
    logic [7:0] r_cnt;
    logic       r_tick;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (i_restart) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (i_enable) begin
            if (r_cnt == i_div) begin
                r_cnt  <= '0;
                r_tick <= 1'b1;
            end else begin
                r_cnt  <= r_cnt + 8'd1;
                r_tick <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign o_tick = r_tick;
endmodule

// File: rtl/riscv_timer_control.sv
// Machine-timer front end: APB registers, prescaler and timer interrupt.
// Optional RISCV_TIMER_SNAPSHOT_EN: mtime_lo read latches the high word for a tear-free hi read.
module riscv_timer_control
    import riscv_timer_pkg::*;
#(
    parameter logic [7:0] DIV_RESET    = 8'd0,
    parameter logic       ENABLE_RESET = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    riscv_timer_control_if.slave        apb,
    input  logic [63:0]                 csrs_time,
    output logic                        timer_inc,
    output logic                        timer_clear,
    output logic                        timer_load,
    output logic [63:0]                 timer_value,
    output logic                        timer_irq
);
    logic            w_access, w_err, w_wr, w_rd;
    logic            w_wr_ctrl, w_load_req, w_clear_req, w_tick;
    logic [63:0]     w_load_value;
    logic [31:0]     w_rdata, w_mtime_hi;
    t_timer_controls w_ctl;

    logic            r_load, r_clear, r_irq, r_enable;
    logic [63:0]     r_value, r_cmp;
    logic [7:0]      r_div;

    assign w_access  = apb.apb_psel & apb.apb_penable;
    assign w_err     = timer_addr_err(apb.apb_paddr);
    assign w_wr      = w_access & apb.apb_pwrite & ~w_err;
    assign w_rd      = w_access & ~apb.apb_pwrite & ~w_err;
    assign w_wr_ctrl = w_wr && (apb.apb_paddr == TIMER_ADDR_CTRL);

    assign w_load_req = w_wr && ((apb.apb_paddr == TIMER_ADDR_MTIME_LO) ||
                                 (apb.apb_paddr == TIMER_ADDR_MTIME_HI));
    // Load wins over clear so the CSR block never sees both at once.
    assign w_clear_req  = w_wr_ctrl & apb.apb_pwdata[CTRL_CLEAR_BIT] & ~w_load_req;
    assign w_load_value = (apb.apb_paddr == TIMER_ADDR_MTIME_LO) ?
                          {csrs_time[63:32], apb.apb_pwdata} :
                          {apb.apb_pwdata, csrs_time[31:0]};

    riscv_timer_prescaler u_prescaler (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_div     (r_div),
        .i_enable  (r_enable),
        .i_restart (w_load_req | w_clear_req),
        .o_tick    (w_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_load   <= 1'b0;
            r_clear  <= 1'b0;
            r_value  <= '0;
            r_cmp    <= '1;
            r_enable <= ENABLE_RESET;
            r_div    <= DIV_RESET;
            r_irq    <= 1'b0;
        end else begin
            r_load  <= w_load_req;
            r_clear <= w_clear_req;
            if (w_load_req)
                r_value <= w_load_value;
            if (w_wr && (apb.apb_paddr == TIMER_ADDR_CMP_LO))
                r_cmp[31:0] <= apb.apb_pwdata;
            if (w_wr && (apb.apb_paddr == TIMER_ADDR_CMP_HI))
                r_cmp[63:32] <= apb.apb_pwdata;
            if (w_wr_ctrl) begin
                r_enable <= apb.apb_pwdata[CTRL_ENABLE_BIT];
                r_div    <= apb.apb_pwdata[CTRL_DIV_MSB:CTRL_DIV_LSB];
            end
            r_irq <= (csrs_time >= r_cmp);
        end
    end

`ifdef RISCV_TIMER_SNAPSHOT_EN
    logic [31:0] r_snap_hi;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_snap_hi <= '0;
        else if (w_rd && (apb.apb_paddr == TIMER_ADDR_MTIME_LO))
            r_snap_hi <= csrs_time[63:32];
    end

    assign w_mtime_hi = r_snap_hi;
`else
    assign w_mtime_hi = csrs_time[63:32];
`endif

    always_comb begin
        w_rdata = '0;
        if (!w_err) begin
            case (apb.apb_paddr)
                TIMER_ADDR_MTIME_LO: w_rdata = csrs_time[31:0];
                TIMER_ADDR_MTIME_HI: w_rdata = w_mtime_hi;
                TIMER_ADDR_CMP_LO:   w_rdata = r_cmp[31:0];
                TIMER_ADDR_CMP_HI:   w_rdata = r_cmp[63:32];
                TIMER_ADDR_CTRL: begin
                    w_rdata[CTRL_ENABLE_BIT]           = r_enable;
                    w_rdata[CTRL_DIV_MSB:CTRL_DIV_LSB] = r_div;
                end
                default:             w_rdata = '0;
            endcase
        end
    end

    assign apb.apb_prdata  = w_rdata;
    assign apb.apb_pready  = 1'b1;
    assign apb.apb_pslverr = w_access & w_err;

    // The CSR block lets inc override load/clear, so a coinciding tick is dropped.
    always_comb begin
        w_ctl       = '0;
        w_ctl.inc   = w_tick & ~r_load & ~r_clear;
        w_ctl.clear = r_clear;
        w_ctl.load  = r_load;
        w_ctl.value = r_value;
    end

    assign timer_inc   = w_ctl.inc;
    assign timer_clear = w_ctl.clear;
    assign timer_load  = w_ctl.load;
    assign timer_value = w_ctl.value;
    assign timer_irq   = r_irq;
endmodule
